iir_sos_mc: RTL

- Multichannel cascaded-biquad IIR filter: N_SECT second-order sections in Direct Form I, time-multiplexed over N_CH independent channels through one shared MAC.
- Successor to the fixed 3-tap single-channel IIR. Adds runtime-writable coefficients, per-channel state memory, a valid/ready input handshake and a tagged output.
- Sits between the sample front-end and downstream DSP, same S(16.15) data format.

---
 rtl/iir_sos_mc.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/iir_sos_mc.sv
// Multichannel cascaded-biquad IIR (Direct Form I) sharing one MAC across all
// channels and sections; per-channel state memory, runtime-writable shared coefficients.
module iir_sos_mc #(
  parameter int NB_DATA   = 16,
  parameter int NBF_DATA  = 15,
  parameter int NB_COEFF  = 16,
  parameter int NBF_COEFF = 14,
  parameter int N_CH      = 4,
  parameter int N_SECT    = 2,
  parameter int NB_CH     = (N_CH > 1) ? $clog2(N_CH) : 1,
  parameter int NB_CADDR  = $clog2(5 * N_SECT)
) (
  input  logic                clock,
  input  logic                i_reset,
  input  logic                i_clear,
  input  logic [NB_DATA-1:0]  i_data,
  input  logic [NB_CH-1:0]    i_ch,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic                i_coeff_we,
  input  logic [NB_CADDR-1:0] i_coeff_addr,
  input  logic [NB_COEFF-1:0] i_coeff_data,
  output logic                o_coeff_err,
  output logic [NB_DATA-1:0]  o_data,
  output logic [NB_CH-1:0]    o_ch,
  output logic                o_valid,
  output logic                o_sat
);

  localparam int NB_PROD = NB_DATA + NB_COEFF;
  localparam int NB_ACC  = NB_PROD + 3;
  localparam int NBF_ACC = NBF_DATA + NBF_COEFF;
  localparam int RND_SH  = NBF_ACC - NBF_DATA - 1;
  localparam int NB_SECT = (N_SECT > 1) ? $clog2(N_SECT) : 1;
  localparam int N_COEFF = 5 * N_SECT;
  localparam logic [NB_ACC-1:0]   RND    = {{(NB_ACC-1){1'b0}}, 1'b1} << RND_SH;
  localparam logic [NB_COEFF-1:0] B0_ONE = {{(NB_COEFF-1){1'b0}}, 1'b1} << NBF_COEFF;

  typedef enum logic [1:0] {IDLE, MAC, WB, OUT} state_t;

  state_t                    state_q, state_d;
  logic [2:0]                k_q, k_d;
  logic [NB_SECT-1:0]        s_q, s_d;
  logic [NB_CH-1:0]          ch_q, ch_d;
  logic [NB_DATA-1:0]        x_q, x_d;
  logic signed [NB_ACC-1:0]  acc_q, acc_d;
  logic                      sat_q, sat_d;
  logic [NB_COEFF-1:0]       coef_q [N_COEFF];
  logic [NB_COEFF-1:0]       coef_d [N_COEFF];
  logic [NB_DATA-1:0]        x1_q [N_CH][N_SECT], x1_d [N_CH][N_SECT];
  logic [NB_DATA-1:0]        x2_q [N_CH][N_SECT], x2_d [N_CH][N_SECT];
  logic [NB_DATA-1:0]        y1_q [N_CH][N_SECT], y1_d [N_CH][N_SECT];
  logic [NB_DATA-1:0]        y2_q [N_CH][N_SECT], y2_d [N_CH][N_SECT];
  logic [NB_DATA-1:0]        o_data_q, o_data_d;
  logic [NB_CH-1:0]          o_ch_q, o_ch_d;
  logic                      o_valid_q, o_valid_d;
  logic                      o_sat_q, o_sat_d;
  logic                      o_coeff_err_q, o_coeff_err_d;

  logic [NB_CADDR-1:0]       caddr_s;
  logic [NB_COEFF-1:0]       coef_s;
  logic [NB_DATA-1:0]        op_s;
  logic [NB_PROD-1:0]        prod_s;
  logic signed [NB_ACC-1:0]  prod_ext_s;
  logic signed [NB_ACC-1:0]  rnd_s;
  logic signed [NB_ACC-1:0]  shf_s;
  logic                      fits_s;
  logic [NB_DATA-1:0]        y_s;

  // Shared MAC datapath: operand select, product, round and saturate
  always_comb begin
    caddr_s = NB_CADDR'(32'(s_q) * 32'd5 + 32'(k_q));
    coef_s  = coef_q[caddr_s];
    case (k_q)
      3'd0:    op_s = x_q;
      3'd1:    op_s = x1_q[ch_q][s_q];
      3'd2:    op_s = x2_q[ch_q][s_q];
      3'd3:    op_s = y1_q[ch_q][s_q];
      3'd4:    op_s = y2_q[ch_q][s_q];
      default: op_s = {NB_DATA{1'b0}};
    endcase
    // Low NB_PROD bits of the sign-extended product are the exact signed product
    prod_s     = {{NB_COEFF{op_s[NB_DATA-1]}}, op_s} * {{NB_DATA{coef_s[NB_COEFF-1]}}, coef_s};
    prod_ext_s = {{(NB_ACC-NB_PROD){prod_s[NB_PROD-1]}}, prod_s};
    rnd_s      = acc_q + RND;
    shf_s      = rnd_s >>> NBF_COEFF;
    fits_s     = (shf_s[NB_ACC-1:NB_DATA-1] == {(NB_ACC-NB_DATA+1){shf_s[NB_ACC-1]}});
    y_s        = fits_s ? shf_s[NB_DATA-1:0]
                        : {shf_s[NB_ACC-1], {(NB_DATA-1){~shf_s[NB_ACC-1]}}};
  end

  // Next-state logic: sequencer, coefficient writes, state memory, outputs
  always_comb begin
    state_d = state_q; k_d = k_q; s_d = s_q; ch_d = ch_q; x_d = x_q;
    acc_d = acc_q; sat_d = sat_q; coef_d = coef_q;
    x1_d = x1_q; x2_d = x2_q; y1_d = y1_q; y2_d = y2_q;
    o_data_d = o_data_q; o_ch_d = o_ch_q; o_valid_d = 1'b0; o_sat_d = 1'b0;
    o_coeff_err_d = i_coeff_we & (state_q != IDLE);

    if (i_coeff_we && (state_q == IDLE) && (i_coeff_addr < NB_CADDR'(N_COEFF))) begin
      coef_d[i_coeff_addr] = i_coeff_data;
    end else begin
      coef_d = coef_q;
    end

    case (state_q)
      IDLE: begin
        if (i_valid) begin
          state_d = MAC; k_d = 3'd0; s_d = {NB_SECT{1'b0}};
          ch_d = i_ch; x_d = i_data; sat_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      MAC: begin
        if (k_q == 3'd0) begin
          acc_d = prod_ext_s;
        end else if (k_q >= 3'd3) begin
          acc_d = acc_q - prod_ext_s;
        end else begin
          acc_d = acc_q + prod_ext_s;
        end
        if (k_q == 3'd4) begin
          k_d = 3'd0; state_d = WB;
        end else begin
          k_d = k_q + 3'd1;
        end
      end
      WB: begin
        x1_d[ch_q][s_q] = x_q;
        x2_d[ch_q][s_q] = x1_q[ch_q][s_q];
        y1_d[ch_q][s_q] = y_s;
        y2_d[ch_q][s_q] = y1_q[ch_q][s_q];
        sat_d = sat_q | ~fits_s;
        x_d   = y_s;
        if (s_q == NB_SECT'(N_SECT - 1)) begin
          state_d = OUT;
        end else begin
          s_d = s_q + NB_SECT'(1); state_d = MAC;
        end
      end
      OUT: begin
        o_data_d = x_q; o_ch_d = ch_q; o_valid_d = 1'b1; o_sat_d = sat_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (i_clear) begin
      state_d = IDLE; o_valid_d = 1'b0; o_sat_d = 1'b0;
      for (int c = 0; c < N_CH; c++) begin
        for (int s = 0; s < N_SECT; s++) begin
          x1_d[c][s] = {NB_DATA{1'b0}}; x2_d[c][s] = {NB_DATA{1'b0}};
          y1_d[c][s] = {NB_DATA{1'b0}}; y2_d[c][s] = {NB_DATA{1'b0}};
        end
      end
    end else begin
      o_valid_d = o_valid_d;
    end
  end

  // State registers; reset leaves a pass-through filter (b0 = 1.0)
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= IDLE; k_q <= 3'd0; s_q <= {NB_SECT{1'b0}}; ch_q <= {NB_CH{1'b0}};
      x_q <= {NB_DATA{1'b0}}; acc_q <= {NB_ACC{1'b0}}; sat_q <= 1'b0;
      for (int i = 0; i < N_COEFF; i++) begin
        coef_q[i] <= ((i % 5) == 0) ? B0_ONE : {NB_COEFF{1'b0}};
      end
      for (int c = 0; c < N_CH; c++) begin
        for (int s = 0; s < N_SECT; s++) begin
          x1_q[c][s] <= {NB_DATA{1'b0}}; x2_q[c][s] <= {NB_DATA{1'b0}};
          y1_q[c][s] <= {NB_DATA{1'b0}}; y2_q[c][s] <= {NB_DATA{1'b0}};
        end
      end
      o_data_q <= {NB_DATA{1'b0}}; o_ch_q <= {NB_CH{1'b0}};
      o_valid_q <= 1'b0; o_sat_q <= 1'b0; o_coeff_err_q <= 1'b0;
    end else begin
      state_q <= state_d; k_q <= k_d; s_q <= s_d; ch_q <= ch_d;
      x_q <= x_d; acc_q <= acc_d; sat_q <= sat_d; coef_q <= coef_d;
      x1_q <= x1_d; x2_q <= x2_d; y1_q <= y1_d; y2_q <= y2_d;
      o_data_q <= o_data_d; o_ch_q <= o_ch_d;
      o_valid_q <= o_valid_d; o_sat_q <= o_sat_d; o_coeff_err_q <= o_coeff_err_d;
    end
  end

  assign o_ready     = (state_q == IDLE);
  assign o_data      = o_data_q;
  assign o_ch        = o_ch_q;
  assign o_valid     = o_valid_q;
  assign o_sat       = o_sat_q;
  assign o_coeff_err = o_coeff_err_q;

endmodule
